// File: rtl/mem_access_unit.sv
// mem_access_unit
// ---------------------------------------------------------------------------
// MEM-stage data-memory access engine for the 5-stage RV32I pipeline.
// Runs one req/gnt/rvalid transaction per load/store held in the EX/MEM
// register. The pipeline is stalled until the response arrives or the
// access times out. Load data is lane-selected and sign/zero-extended.
// Store byte enables and lane-replicated write data are also generated here.
//
// Parameters:
//   TIMEOUT          max cycles from request issue to rvalid (2..255)
//
// Optional feature:
//   MISALIGN_TRAP_EN when defined, misaligned LH/LHU/SH/LW/SW accesses are
//                    not sent to the bus. They complete in one cycle and
//                    pulse the extra 'misaligned' output. When the macro is
//                    undefined, the low address bits are only used for lane
//                    selection.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   MEM_mem_read/MEM_mem_write load / store present in MEM stage
//   MEM_funct3, MEM_addr       access size/sign, byte address
//   MEM_write_data             store source value
//   dmem_req/we/addr/be/wdata  bus request channel (zero when no request)
//   dmem_gnt, dmem_rvalid      bus accept / response strobes
//   dmem_rdata                 bus read word
//   mem_stall                  freeze upstream pipeline registers
//   MEM_read_data              extended load result to MEM/WB
//   bus_error                  one-cycle pulse when an access times out
//   misaligned                 (MISALIGN_TRAP_EN only) one-cycle trap pulse
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MEM_mem_read,
    input  logic        MEM_mem_write,
    input  logic [2:0]  MEM_funct3,
    input  logic [31:0] MEM_addr,
    input  logic [31:0] MEM_write_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] MEM_read_data,
    output logic        bus_error
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        misaligned
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    // Abort fires when the incremented count would reach TIMEOUT-1. Using >=
    // also covers a late gnt in REQ that pushes the count past the limit.
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT - 2);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        berr_q, berr_d;
    logic        access;
    logic        trap;
    logic        to_hit;
    logic        is_half;
    logic        is_word;
    logic [1:0]  offset;

    // Lane select plus sign/zero extension. Unknown funct3 codes behave as LW.
    function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                                input logic [1:0]  o,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (o)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = o[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  extend_load = {{24{b[7]}}, b};
            3'b100:  extend_load = {24'd0, b};
            3'b001:  extend_load = {{16{h[15]}}, h};
            3'b101:  extend_load = {16'd0, h};
            default: extend_load = w;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3,
                                            input logic [1:0] o);
        case (f3)
            3'b000:  store_be = 4'b0001 << o;
            3'b001:  store_be = o[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0]  f3,
                                                input logic [31:0] wd);
        case (f3)
            3'b000:  store_wdata = {4{wd[7:0]}};
            3'b001:  store_wdata = {2{wd[15:0]}};
            default: store_wdata = wd;
        endcase
    endfunction

    assign access = MEM_mem_read | MEM_mem_write;
    assign offset = MEM_addr[1:0];
    assign to_hit = (cnt_q >= TO_LIM);

    // Access width: funct3 100/101 are byte/half only for loads; for stores
    // every code other than SB/SH is a word store.
    assign is_half = (MEM_funct3 == 3'b001) | (MEM_mem_read & (MEM_funct3 == 3'b101));
    assign is_word = ~is_half & (MEM_funct3 != 3'b000)
                   & ~(MEM_mem_read & (MEM_funct3 == 3'b100));

`ifdef MISALIGN_TRAP_EN
    logic mis_q, mis_d;
    assign trap       = access & ((is_half & offset[0]) | (is_word & (offset != 2'b00)));
    assign misaligned = mis_q;
`else
    assign trap = 1'b0;
`endif

    // State register and bus-result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            berr_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            berr_q  <= berr_d;
`ifdef MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        berr_d  = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (trap) begin
                    state_d = DONE;
                    rdata_d = '0;
`ifdef MISALIGN_TRAP_EN
                    mis_d   = 1'b1;
`endif
                end else if (access) begin
                    state_d = dmem_gnt ? RESP : REQ;
                end
            end
            REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (dmem_gnt) begin
                    state_d = RESP;
                end else if (to_hit) begin
                    state_d = DONE;
                    rdata_d = '0;
                    berr_d  = 1'b1;
                end
            end
            RESP: begin
                cnt_d = cnt_q + 8'd1;
                if (dmem_rvalid) begin
                    state_d = DONE;
                    rdata_d = MEM_mem_read ? extend_load(MEM_funct3, offset, dmem_rdata)
                                           : 32'd0;
                end else if (to_hit) begin
                    state_d = DONE;
                    rdata_d = '0;
                    berr_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Bus request channel: combinational in IDLE so zero-wait grants cost no cycle
    always_comb begin
        dmem_req   = ((state_q == IDLE) & access & ~trap) | (state_q == REQ);
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_be    = '0;
        dmem_wdata = '0;
        if (dmem_req) begin
            dmem_we    = MEM_mem_write;
            dmem_addr  = {MEM_addr[31:2], 2'b00};
            dmem_be    = store_be(MEM_funct3, offset);
            dmem_wdata = store_wdata(MEM_funct3, MEM_write_data);
        end
    end

    assign mem_stall     = access & (state_q != DONE);
    assign MEM_read_data = rdata_q;
    assign bus_error     = berr_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access engine of the 5-stage RV32I pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB register.
- Takes address (MEM-stage ALU result), store data and funct3. Runs a req/gnt/rvalid transaction on the data-memory bus, stalling the pipeline until the transaction completes.
- Delivers aligned, sign/zero-extended load data to the MEM/WB register input. Also generates store byte enables and lane-replicated write data.

Parameters:
- TIMEOUT, 16: max cycles from request issue to rvalid before the access is aborted as a bus error; range 2..255.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- MEM_mem_read  in  1  load in MEM stage.
- MEM_mem_write  in  1  store in MEM stage; never both set with MEM_mem_read.
- MEM_funct3  in  3  access size/sign, RV32I encoding.
- MEM_addr  in  32  byte address (ALU result).
- MEM_write_data  in  32  store source register value.
- dmem_req  out  1  bus request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word address, {MEM_addr[31:2],2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-aligned write data.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  response valid; required for both reads and writes.
- dmem_rdata  in  32  read word.
- mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; hold MEM/WB input.
- MEM_read_data  out  32  extended load result to MEM/WB.
- bus_error  out  1  one-cycle pulse on timeout.

Behaviour:
- Access definition: access = MEM_mem_read | MEM_mem_write.
- FSM states: IDLE, REQ, RESP, DONE. Reset: state IDLE, timeout counter 0, read-data register 0, bus_error 0. All outputs derived from these, so after reset dmem_req=0, mem_stall=0, MEM_read_data=0.
- IDLE:
  - access & dmem_gnt -> RESP.
  - access & !dmem_gnt -> REQ.
  - no access -> stay in IDLE.
- REQ: dmem_gnt -> RESP.
- RESP: dmem_rvalid -> DONE. On this edge capture the extended dmem_rdata (loads) or 0 (stores) into the read-data register.
- DONE: unconditional -> IDLE. The pipeline advances on this edge, so the next instruction is seen in IDLE. Throughput is 1 access per 3 cycles minimum (IDLE, RESP, DONE) with zero-wait gnt/rvalid.
- dmem_req = (state==IDLE & access) | state==REQ. Request is combinational in IDLE.
- dmem_we, dmem_addr, dmem_be, dmem_wdata are valid whenever dmem_req=1; 0 otherwise.
- mem_stall = access & state!=DONE. Combinational.
- MEM_read_data = read-data register; value is stable throughout DONE.
- Timeout counter:
  - cleared in IDLE; increments each cycle in REQ or RESP.
  - Reaching TIMEOUT-1 with no gnt/rvalid -> DONE. Read-data register = 0; bus_error pulses 1 for exactly the DONE cycle.
  - A late rvalid after abort is ignored.
- Load extension, from the byte offset o=MEM_addr[1:0]:
  - LB 000: sext of byte o.
  - LBU 100: zext of byte o.
  - LH 001: sext of half o[1].
  - LHU 101: zext of half o[1].
  - LW 010: full word.
  - Other funct3 values: treated as LW.
- Store encoding:
  - SB: be=4'b0001<<o, wdata={4{wd[7:0]}}.
  - SH: be = o[1] ? 1100 : 0011, wdata={2{wd[15:0]}}.
  - SW / other: be=1111, wdata=wd.
- Misalignment without the optional feature: low address bits ignored beyond lane selection. LW at 0x...2 reads the whole word 0x...0; LH at odd address uses half o[1].
- Simultaneous gnt & rvalid in the same cycle while in IDLE: gnt is honoured, rvalid ignored; rvalid is only sampled in RESP.
- Reset mid-transaction: FSM returns to IDLE immediately and dmem_req drops asynchronously. Any outstanding bus response is dropped by the bus on reset.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- With the macro defined:
  - Extra output port misaligned (1 bit).
  - An LH/LHU/SH access with o[0]=1, or an LW/SW access with o!=0, issues no bus request. FSM goes IDLE->DONE in one cycle; mem_stall=1 for that one cycle.
  - misaligned pulses 1 during DONE; read-data register = 0; no store is performed.
- Without the macro: the port is absent and the truncation rules above apply.

Test Plan:
- LB addr 0x1003, rdata 0x80112233, gnt/rvalid zero-wait -> be n/a, dmem_addr 0x1000, mem_stall 1 for 2 cycles, MEM_read_data 0xFFFFFF80 in DONE.
- SH addr 0x2002, wd 0x0000BEEF -> dmem_we 1, be 1100, wdata 0xBEEFBEEF, dmem_addr 0x2000; MEM_read_data 0.
- LHU addr 0x3000, gnt delayed 3 cycles, rvalid delayed 2 more, rdata 0x1234F00D -> stays REQ 3 cycles then RESP, MEM_read_data 0x0000F00D, total stall 6 cycles.
- LW with gnt but no rvalid, TIMEOUT=16 -> DONE after 16 stall cycles, bus_error high 1 cycle, MEM_read_data 0; later rvalid ignored.
- Reset asserted while in RESP -> dmem_req, mem_stall (with access deasserted), MEM_read_data all 0 immediately; next LW after reset completes normally.
- MISALIGN_TRAP_EN: LW addr 0x4001 -> dmem_req never asserted, mem_stall 1 for one cycle, misaligned pulses 1, MEM_read_data 0.
